// File: rtl/window3x3_gen_pkg.sv
// Shared definitions for the raster-to-window stage and its neighbours in the pipeline.
// The pixel width default here must also be used by the downstream sorter.
package window3x3_gen_pkg;

  localparam int unsigned DefaultDataWidth = 8;

  // Window grid is 3x3; the centre sits one row/column behind the newest pixel.
  localparam int unsigned WinSize   = 3;
  localparam int unsigned WinMargin = WinSize - 1;

endpackage

// File: rtl/line_buffer.sv
// One-line delay: data_o is data_i delayed by DEPTH enabled cycles.
// Storage is a wrapping-address RAM and is deliberately not reset.
module line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrWidth-1:0]  ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == AddrWidth'(DEPTH - 1)) ? '0 : ptr_q + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  // Read-before-write: the slot about to be overwritten holds the sample from one line ago.
  assign data_o = mem_q[ptr_q];

endmodule

// File: rtl/window3x3_gen.sv
// Raster-to-3x3-window stage: two line buffers feed a 3x3 shift window; only windows fully
// inside the image are flagged valid, with the centre coordinates.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [DATA_WIDTH-1:0]  in_pixel,
  output logic [DATA_WIDTH-1:0]  w1,
  output logic [DATA_WIDTH-1:0]  w2,
  output logic [DATA_WIDTH-1:0]  w3,
  output logic [DATA_WIDTH-1:0]  w4,
  output logic [DATA_WIDTH-1:0]  w5,
  output logic [DATA_WIDTH-1:0]  w6,
  output logic [DATA_WIDTH-1:0]  w7,
  output logic [DATA_WIDTH-1:0]  w8,
  output logic [DATA_WIDTH-1:0]  w9,
  output logic                   out_valid,
  output logic [COORD_WIDTH-1:0] out_row,
  output logic [COORD_WIDTH-1:0] out_col,
  output logic                   frame_done
);

  logic [COORD_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic [COORD_WIDTH-1:0] row_pos, col_pos;
  logic                   last_col, last_row, win_pos;
  logic [COORD_WIDTH-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic                   out_valid_q, frame_done_q;
  logic [DATA_WIDTH-1:0]  lb0_out, lb1_out;
  logic [DATA_WIDTH-1:0]  top_q [WinSize];
  logic [DATA_WIDTH-1:0]  mid_q [WinSize];
  logic [DATA_WIDTH-1:0]  bot_q [WinSize];

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_lb0 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (in_valid),
    .data_i (in_pixel),
    .data_o (lb0_out)
  );

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (in_valid),
    .data_i (lb0_out),
    .data_o (lb1_out)
  );

  // in_sof overrides the counters so the qualifying pixel is taken as (0, 0).
  always_comb begin
    row_pos  = in_sof ? '0 : row_q;
    col_pos  = in_sof ? '0 : col_q;
    last_col = (col_pos == COORD_WIDTH'(IMG_WIDTH - 1));
    last_row = (row_pos == COORD_WIDTH'(IMG_HEIGHT - 1));
    win_pos  = in_valid && (row_pos >= COORD_WIDTH'(WinMargin))
                        && (col_pos >= COORD_WIDTH'(WinMargin));
    row_d    = row_q;
    col_d    = col_q;
    if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_pos + COORD_WIDTH'(1);
      end else begin
        col_d = col_pos + COORD_WIDTH'(1);
        row_d = row_pos;
      end
    end
  end

  always_comb begin
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (win_pos) begin
      out_row_d = row_pos - COORD_WIDTH'(1);
      out_col_d = col_pos - COORD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= win_pos;
      frame_done_q <= in_valid && last_col && last_row;
    end
  end

  // Columns are not cleared at line start; the col >= 2 guard hides wrapped columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WinSize; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else if (in_valid) begin
      for (int i = 0; i < WinSize - 1; i++) begin
        top_q[i] <= top_q[i+1];
        mid_q[i] <= mid_q[i+1];
        bot_q[i] <= bot_q[i+1];
      end
      top_q[WinSize-1] <= lb1_out;
      mid_q[WinSize-1] <= lb0_out;
      bot_q[WinSize-1] <= in_pixel;
    end
  end

  assign w1         = top_q[0];
  assign w2         = top_q[1];
  assign w3         = top_q[2];
  assign w4         = mid_q[0];
  assign w5         = mid_q[1];
  assign w6         = mid_q[2];
  assign w7         = bot_q[0];
  assign w8         = bot_q[1];
  assign w9         = bot_q[2];
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 4x4 image: a frame-array reference model predicts every window,
// valid strobe and frame_done pulse cycle by cycle.
module tb_window3x3_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_sof;
  logic [DW-1:0] in_pixel;
  logic [DW-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic          out_valid, frame_done;
  logic [CW-1:0] out_row, out_col;

  int n_vec = 0;
  int n_err = 0;
  int dut_win = 0;
  int mrow = 0;
  int mcol = 0;
  logic [DW-1:0] img [H][W];

  window3x3_gen #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .COORD_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .w4         (w4),
    .w5         (w5),
    .w6         (w6),
    .w7         (w7),
    .w8         (w8),
    .w9         (w9),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model is the raw frame array indexed by raster position.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    logic        exp_v, exp_fd;
    logic [71:0] ew;
    int          r, c;
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    ew     = '0;
    r      = 0;
    c      = 0;
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    if (v) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      r = mrow;
      c = mcol;
      img[r][c] = p;
      exp_v  = (r >= 2) && (c >= 2);
      exp_fd = (r == H - 1) && (c == W - 1);
      if (exp_v) begin
        for (int k = 0; k < 9; k++) begin
          ew[(8-k)*8 +: 8] = img[r-2+k/3][c-2+k%3];
        end
      end
      mcol = mcol + 1;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow + 1) % H;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (out_valid === 1'b1) dut_win++;
    chk("out_valid", {71'd0, out_valid}, {71'd0, exp_v});
    chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
    if (exp_v) begin
      chk("window", {w1, w2, w3, w4, w5, w6, w7, w8, w9}, ew);
      chk("out_row", {62'd0, out_row}, 72'(r - 1));
      chk("out_col", {62'd0, out_col}, 72'(c - 1));
    end
  endtask

  // Drives pixels [first, W*H) of a frame; gap = idle cycles after each pixel, -1 for random.
  task automatic frame(input logic sof, input int first, input int gap, input logic rnd);
    logic [DW-1:0] p;
    int            n_idle;
    for (int i = first; i < W * H; i++) begin
      p = rnd ? DW'($urandom_range(0, 255)) : DW'(16 * (i / W) + (i % W));
      step(1'b1, sof && (i == first), p);
      n_idle = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int g = 0; g < n_idle; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic frame_count(input string tag, input logic sof, input int gap, input logic rnd);
    int w0;
    w0 = dut_win;
    frame(sof, 0, gap, rnd);
    chk(tag, 72'(dut_win - w0), 72'd4);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    #12;
    chk("reset_outputs", {w1, w2, w3, w4, w5, w6, w7, w8, w9}, '0);
    chk("reset_flags", {62'd0, out_valid, frame_done, out_row[3:0], out_col[3:0]}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    frame_count("windows_contiguous", 1'b1, 0, 1'b0);
    frame_count("windows_gap3", 1'b1, 3, 1'b0);
    frame_count("windows_random", 1'b1, -1, 1'b1);

    // Abandon a frame at pixel 9 by restarting with in_sof.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 255)));
    frame_count("windows_after_sof", 1'b1, 0, 1'b0);

    // Asynchronous reset in the middle of row 2, away from the clock edge.
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, DW'(16 * (i / W) + (i % W)));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_window", {w1, w2, w3, w4, w5, w6, w7, w8, w9}, '0);
    chk("async_rst_flags", {52'd0, out_valid, frame_done, out_row, out_col}, '0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    mrow = 0;
    mcol = 0;
    frame_count("windows_after_rst", 1'b0, 0, 1'b0);

    // Back-to-back frames, the second without in_sof, no gap.
    frame_count("b2b_first", 1'b1, 0, 1'b1);
    frame_count("b2b_second", 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
